// File: rtl/ats21_cmd_sequencer.sv
// ATS21 command sequencer: two client instruction queues feeding a single
// ATS21 device through a request / ready / two-half-word / status handshake.
// Conflicting instructions (same target object) are serialized with a
// toggling priority between the two clients.

module ats21_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] head,
  output logic        full,
  output logic        empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array: written at the tail, no reset needed since count guards reads
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping with explicit wrap for non-power-of-2 depths
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end
endmodule

module ats21_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int STAT_WAIT  = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [31:0] a_inst,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [31:0] b_inst,
  output logic        b_ready,
  output logic        dev_req,
  input  logic        dev_ready,
  output logic [15:0] dev_ctrlA,
  output logic [15:0] dev_ctrlB,
  input  logic [1:0]  dev_stat,
  output logic        a_done,
  output logic        a_ack,
  output logic        b_done,
  output logic        b_ack,
  output logic        timeout,
  output logic        busy
);
  localparam int CMAX = (TIMEOUT > STAT_WAIT) ? TIMEOUT : STAT_WAIT;
  localparam int CNTW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_RDY, LO, STAT, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic [CNTW-1:0] cnt;
  logic [31:0] slot_a;
  logic [31:0] slot_b;
  logic        a_live;
  logic        b_live;
  logic        prio;
  logic        to_flag;

  logic [31:0] a_head;
  logic [31:0] b_head;
  logic        a_full;
  logic        b_full;
  logic        a_empty;
  logic        b_empty;
  logic        a_pop;
  logic        b_pop;
  logic        conflict;
  logic        a_take;
  logic        b_take;

  assign a_ready = !a_full;
  assign b_ready = !b_full;
  assign a_pop   = (state == RESP) && a_live;
  assign b_pop   = (state == RESP) && b_live;

  ats21_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(clk), .reset(reset), .push(a_valid), .pop(a_pop), .din(a_inst),
    .head(a_head), .full(a_full), .empty(a_empty)
  );

  ats21_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(clk), .reset(reset), .push(b_valid), .pop(b_pop), .din(b_inst),
    .head(b_head), .full(b_full), .empty(b_empty)
  );

  // Object-conflict detection between the two queue heads
  always_comb begin
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic       grp1_a, grp1_b, grp2_a, grp2_b, grp3_a, grp3_b;
    op_a   = a_head[31:29];
    op_b   = b_head[31:29];
    grp1_a = (op_a == 3'b001) || (op_a == 3'b010);
    grp1_b = (op_b == 3'b001) || (op_b == 3'b010);
    grp2_a = (op_a == 3'b101) || (op_a == 3'b110) || (op_a == 3'b111);
    grp2_b = (op_b == 3'b101) || (op_b == 3'b110) || (op_b == 3'b111);
    grp3_a = (op_a == 3'b011);
    grp3_b = (op_b == 3'b011);
    conflict = !a_empty && !b_empty &&
               ((grp1_a && grp1_b && (a_head[28:25] == b_head[28:25])) ||
                (grp2_a && grp2_b && (a_head[28:24] == b_head[28:24])) ||
                (grp3_a && grp3_b));
    a_take = !a_empty && !(conflict && prio);
    b_take = !b_empty && !(conflict && !prio);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic for the device handshake
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (!a_empty || !b_empty) state_next = REQ;
      REQ:      state_next = WAIT_RDY;
      WAIT_RDY: begin
        if (dev_ready)                          state_next = LO;
        else if (cnt == CNTW'(TIMEOUT - 1))     state_next = RESP;
      end
      LO:       state_next = STAT;
      STAT:     if (cnt == CNTW'(STAT_WAIT - 1)) state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Slot capture, priority toggle, dwell counter and timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      slot_a  <= '0;
      slot_b  <= '0;
      a_live  <= 1'b0;
      b_live  <= 1'b0;
      prio    <= 1'b0;
      to_flag <= 1'b0;
    end else begin
      if (state_next != state) cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + CNTW'(1);

      if (state == IDLE && state_next == REQ) begin
        slot_a <= a_take ? a_head : 32'h0;
        slot_b <= b_take ? b_head : 32'h0;
        a_live <= a_take;
        b_live <= b_take;
        if (conflict) prio <= !prio;
      end

      if (state == WAIT_RDY && state_next == RESP) to_flag <= 1'b1;
      else if (state == RESP)                      to_flag <= 1'b0;
    end
  end

  // Moore outputs per state, with completion status sampled in RESP
  always_comb begin
    dev_req   = 1'b0;
    dev_ctrlA = 16'h0;
    dev_ctrlB = 16'h0;
    a_done    = 1'b0;
    a_ack     = 1'b0;
    b_done    = 1'b0;
    b_ack     = 1'b0;
    timeout   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      REQ: begin
        dev_req   = 1'b1;
        dev_ctrlA = slot_a[31:16];
        dev_ctrlB = slot_b[31:16];
      end
      WAIT_RDY: begin
        dev_ctrlA = slot_a[31:16];
        dev_ctrlB = slot_b[31:16];
      end
      LO: begin
        dev_ctrlA = slot_a[15:0];
        dev_ctrlB = slot_b[15:0];
      end
      RESP: begin
        a_done  = a_live;
        b_done  = b_live;
        a_ack   = a_live && !to_flag && dev_stat[0];
        b_ack   = b_live && !to_flag && dev_stat[1];
        timeout = to_flag;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ats21_cmd_sequencer.sv
// Directed testbench for ats21_cmd_sequencer with hand-computed expectations.

module tb_ats21_cmd_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic [31:0] a_inst, b_inst;
  logic        a_ready, b_ready;
  logic        dev_req, dev_ready;
  logic [15:0] dev_ctrlA, dev_ctrlB;
  logic [1:0]  dev_stat;
  logic        a_done, a_ack, b_done, b_ack, timeout, busy;

  int n_vec = 0;
  int n_err = 0;

  ats21_cmd_sequencer dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_inst(a_inst), .a_ready(a_ready),
    .b_valid(b_valid), .b_inst(b_inst), .b_ready(b_ready),
    .dev_req(dev_req), .dev_ready(dev_ready),
    .dev_ctrlA(dev_ctrlA), .dev_ctrlB(dev_ctrlB), .dev_stat(dev_stat),
    .a_done(a_done), .a_ack(a_ack), .b_done(b_done), .b_ack(b_ack),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_both(input logic va, input logic [31:0] ia,
                           input logic vb, input logic [31:0] ib);
    a_valid = va; a_inst = ia;
    b_valid = vb; b_inst = ib;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic do_transaction(input logic [15:0] ahi, input logic [15:0] alo,
                                input logic [15:0] bhi, input logic [15:0] blo,
                                input logic exp_a, input logic exp_b,
                                input logic [1:0] stat, input string name);
    for (int i = 0; i < 10 && dev_req !== 1'b1; i++) tick();
    n_vec++;
    if (dev_req !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL %s req_wait: got dev_req=%b expected 1", name, dev_req);
      return;
    end
    n_vec++;
    if (dev_ctrlA !== ahi || dev_ctrlB !== bhi) begin
      n_err++;
      $display("[TB] FAIL %s req_hi: got %h/%h expected %h/%h", name, dev_ctrlA, dev_ctrlB, ahi, bhi);
    end
    tick();
    dev_ready = 1'b1;
    n_vec++;
    if (dev_req !== 1'b0 || dev_ctrlA !== ahi || dev_ctrlB !== bhi) begin
      n_err++;
      $display("[TB] FAIL %s wait_hi: got req=%b %h/%h expected req=0 %h/%h", name, dev_req, dev_ctrlA, dev_ctrlB, ahi, bhi);
    end
    tick();
    dev_ready = 1'b0;
    n_vec++;
    if (dev_ctrlA !== alo || dev_ctrlB !== blo) begin
      n_err++;
      $display("[TB] FAIL %s lo: got %h/%h expected %h/%h", name, dev_ctrlA, dev_ctrlB, alo, blo);
    end
    dev_stat = stat;
    tick();
    tick();
    n_vec++;
    if (dev_ctrlA !== 16'h0 || dev_ctrlB !== 16'h0 || a_done !== 1'b0 || b_done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s stat: got %h/%h done=%b%b expected 0000/0000 done=00", name, dev_ctrlA, dev_ctrlB, a_done, b_done);
    end
    tick();
    n_vec++;
    if (a_done !== exp_a || b_done !== exp_b ||
        a_ack !== (exp_a & stat[0]) || b_ack !== (exp_b & stat[1]) || timeout !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s resp: got done=%b%b ack=%b%b to=%b expected done=%b%b ack=%b%b to=0",
               name, a_done, b_done, a_ack, b_ack, timeout, exp_a, exp_b, exp_a & stat[0], exp_b & stat[1]);
    end
    tick();
    n_vec++;
    if (a_done !== 1'b0 || b_done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s after_resp: got done=%b%b expected 00", name, a_done, b_done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_ready: got %b%b expected 11", a_ready, b_ready);
    end
    n_vec++;
    if (dev_req !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_ctl: got req=%b busy=%b to=%b expected 0 0 0", dev_req, busy, timeout);
    end
    n_vec++;
    if (dev_ctrlA !== 16'h0 || dev_ctrlB !== 16'h0) begin
      n_err++;
      $display("[TB] FAIL reset_ctrl: got %h/%h expected 0000/0000", dev_ctrlA, dev_ctrlB);
    end
    n_vec++;
    if (a_done !== 1'b0 || b_done !== 1'b0 || a_ack !== 1'b0 || b_ack !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_done: got %b%b%b%b expected 0000", a_done, b_done, a_ack, b_ack);
    end
  endtask

  task automatic test_basic();
    do_reset();
    push_both(1'b1, 32'h22000005, 1'b0, 32'h0);
    do_transaction(16'h2200, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b01, "basic");
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL basic_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    push_both(1'b1, 32'hA5000010, 1'b1, 32'hA5000020);
    do_transaction(16'hA500, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b11, "conf1");
    do_transaction(16'h0000, 16'h0000, 16'hA500, 16'h0020, 1'b0, 1'b1, 2'b11, "conf2");
    push_both(1'b1, 32'hA5000030, 1'b1, 32'hA5000040);
    do_transaction(16'h0000, 16'h0000, 16'hA500, 16'h0040, 1'b0, 1'b1, 2'b11, "conf3");
    do_transaction(16'hA500, 16'h0030, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b11, "conf4");
  endtask

  task automatic test_timeout();
    logic early;
    do_reset();
    dev_stat = 2'b11;
    push_both(1'b1, 32'h22000005, 1'b0, 32'h0);
    for (int i = 0; i < 10 && dev_req !== 1'b1; i++) tick();
    n_vec++;
    if (dev_req !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL to_req_wait: got dev_req=%b expected 1", dev_req);
    end
    early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (timeout !== 1'b0 || a_done !== 1'b0 || dev_ctrlA !== 16'h2200) early = 1'b1;
    end
    n_vec++;
    if (early !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL to_wait: got early/bad activity=%b expected 0", early);
    end
    tick();
    n_vec++;
    if (timeout !== 1'b1 || a_done !== 1'b1 || a_ack !== 1'b0 || b_done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL to_resp: got to=%b a_done=%b a_ack=%b b_done=%b expected 1 1 0 0", timeout, a_done, a_ack, b_done);
    end
    tick();
    tick();
    n_vec++;
    if (busy !== 1'b0 || dev_req !== 1'b0 || timeout !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL to_idle: got busy=%b req=%b to=%b expected 0 0 0", busy, dev_req, timeout);
    end
    dev_stat = 2'b00;
  endtask

  task automatic test_full();
    int dones;
    do_reset();
    dev_ready = 1'b0;
    dev_stat  = 2'b00;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (a_ready !== (i < 4)) begin
        n_err++;
        $display("[TB] FAIL full_ready%0d: got %b expected %b", i, a_ready, (i < 4));
      end
      a_valid = 1'b1;
      a_inst  = 32'h20000001 + i;
      tick();
    end
    a_valid = 1'b0;
    for (int i = 0; i < 40 && a_done !== 1'b1; i++) tick();
    n_vec++;
    if (a_done !== 1'b1 || a_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL full_resp: got a_done=%b a_ready=%b expected 1 0", a_done, a_ready);
    end
    tick();
    n_vec++;
    if (a_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL full_release: got a_ready=%b expected 1", a_ready);
    end
    dev_ready = 1'b1;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (a_done === 1'b1) dones++;
    end
    dev_ready = 1'b0;
    n_vec++;
    if (dones !== 3 || busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL full_drain: got %0d dones busy=%b expected 3 dones busy=0", dones, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_reset();
    push_both(1'b1, 32'h22000005, 1'b1, 32'h24000007);
    push_both(1'b1, 32'h22000009, 1'b0, 32'h0);
    for (int i = 0; i < 10 && dev_req !== 1'b1; i++) tick();
    tick();
    dev_ready = 1'b1;
    tick();
    dev_ready = 1'b0;
    n_vec++;
    if (dev_ctrlA !== 16'h0005 || dev_ctrlB !== 16'h0007) begin
      n_err++;
      $display("[TB] FAIL mid_lo: got %h/%h expected 0005/0007", dev_ctrlA, dev_ctrlB);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (dev_req !== 1'b0 || dev_ctrlA !== 16'h0 || dev_ctrlB !== 16'h0 || busy !== 1'b0 ||
        a_done !== 1'b0 || b_done !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL mid_reset: got req=%b ctrl=%h/%h busy=%b done=%b%b rdy=%b%b expected 0 0000/0000 0 00 11",
               dev_req, dev_ctrlA, dev_ctrlB, busy, a_done, b_done, a_ready, b_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dev_req !== 1'b0 || a_done !== 1'b0 || b_done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mid_quiet: got activity=%b expected 0", seen);
    end
  endtask

  task automatic test_mode();
    do_reset();
    push_both(1'b1, 32'h70000000, 1'b1, 32'h6C000000);
    do_transaction(16'h7000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b10, "mode1");
    do_transaction(16'h0000, 16'h0000, 16'h6C00, 16'h0000, 1'b0, 1'b1, 2'b10, "mode2");
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_inst = 32'h0; b_inst = 32'h0;
    dev_ready = 1'b0;
    dev_stat = 2'b00;
    test_reset();
    test_basic();
    test_conflict();
    test_timeout();
    test_full();
    test_reset_mid();
    test_mode();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ats21_cmd_sequencer.md
ATS21_CMD_SEQUENCER -- requirements
Module: ats21_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the per-client instruction queue depth.
REQ-002 Parameter STAT_WAIT, default 2, SHALL set the cycles between the last half-word and status sampling.
REQ-003 Parameter TIMEOUT, default 16, SHALL set the maximum cycles spent waiting for dev_ready.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Ports a_valid/b_valid, input, 1: client offers a 32-bit instruction.
REQ-007 Ports a_inst/b_inst, input, 32: client instruction word, opcode in [31:29].
REQ-008 Ports a_ready/b_ready, output, 1: client queue not full.
REQ-009 Port dev_req, output, 1: request pulse to the ATS21.
REQ-010 Port dev_ready, input, 1: ATS21 ready indication.
REQ-011 Ports dev_ctrlA/dev_ctrlB, output, 16: half-word command buses.
REQ-012 Port dev_stat, input, 2: ATS21 status, bit0 = client A ack, bit1 = client B ack.
REQ-013 Ports a_done/b_done, output, 1: one-cycle completion pulse per client.
REQ-014 Ports a_ack/b_ack, output, 1: completion result, valid only with the matching done pulse.
REQ-015 Port timeout, output, 1: one-cycle pulse when dev_ready never arrived.
REQ-016 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-017 Queues: push when x_valid and x_ready; x_ready = !full only, with no bypass when full; pop only in RESP.
REQ-018 FSM states SHALL be IDLE, REQ, WAIT_RDY, LO, STAT, RESP.
REQ-019 IDLE -> REQ when either queue is non-empty; the slot instructions are latched on that edge.
REQ-020 Slot fill: each slot takes the head of its own queue, or 32'h0 (NOP) if that queue is empty.
REQ-021 A conflict exists when the two heads address the same object: both opcodes in {001,010} with equal [28:25]; both in {101,110,111} with equal [28:24]; or both opcode 011.
REQ-022 On conflict, the client favoured by prio SHALL issue and the other slot carries NOP with its head retained; prio then toggles (reset value: A).
REQ-023 REQ: dev_req=1 for exactly one cycle, then WAIT_RDY.
REQ-024 REQ and WAIT_RDY: dev_ctrlA/B carry slot [31:16].
REQ-025 WAIT_RDY: an edge sampling dev_ready=1 goes to LO; after TIMEOUT cycles without dev_ready, go to RESP with timeout flagged.
REQ-026 LO: dev_ctrlA/B carry slot [15:0] for exactly one cycle, then STAT.
REQ-027 STAT: hold for STAT_WAIT cycles with dev_ctrl=0, then RESP.
REQ-028 RESP (one cycle): x_done=1 only for slots carrying a dequeued instruction, with a_ack=dev_stat[0] and b_ack=dev_stat[1].
REQ-029 RESP on timeout: done with ack=0, timeout=1, and the slots popped anyway; then IDLE.
REQ-030 dev_ctrlA/B SHALL be 0 in IDLE, STAT and RESP.
REQ-031 Latency: with dev_ready one cycle after dev_req, x_done SHALL occur 5 cycles after the dev_req cycle.

Reset
REQ-032 Reset (sync, any state, including mid-transaction) SHALL give state IDLE, both queues empty, prio=A.
REQ-033 Reset SHALL drive all outputs 0 except a_ready=b_ready=1.
REQ-034 A transaction interrupted by reset SHALL produce no done pulse.

Verification
REQ-035 A pushes 0x22000005, B empty, device ready 1 cycle after req, stat=2'b01 -> dev_ctrlA 0x2200 then 0x0005; dev_ctrlB 0x0000 both halves; a_done=1 and a_ack=1 at dev_req cycle+5; no b_done.
REQ-036 A 0xA5000010 and B 0xA5000020 (both alarm 5) -> first transaction A plus NOP, second B plus NOP; a later conflict issues B first.
REQ-037 Device never raises dev_ready -> timeout=1 and a_done with a_ack=0 after 16 WAIT_RDY cycles; queue popped; FSM back to IDLE.
REQ-038 Device stalled, A pushes 5 -> a_ready=0 after 4 entries and the 5th is not accepted; a_ready=1 in the cycle after the first RESP.
REQ-039 Reset asserted during LO -> next cycle dev_req=0, dev_ctrl=0, busy=0, queues empty, no done pulse.
REQ-040 A 0x70000000 and B 0x6C000000 (both mode writes) -> two serialized transactions, each paired with NOP.
